// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipeline_ctrl_pkg : shared exception codes, stall bus encodings and FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  localparam int unsigned c_exc_code_w = 5;
  typedef logic [c_exc_code_w-1:0] exc_code_t;

  localparam exc_code_t c_ec_int     = 5'h00;
  localparam exc_code_t c_ec_syscall = 5'h08;
  localparam exc_code_t c_ec_break   = 5'h09;
  localparam exc_code_t c_ec_ri      = 5'h0a;
  localparam exc_code_t c_ec_ov      = 5'h0c;
  localparam exc_code_t c_ec_none    = 5'h10;
  localparam exc_code_t c_ec_eret    = 5'h11;

  localparam logic c_stop   = 1'b1;
  localparam logic c_nostop = 1'b0;

  localparam int unsigned c_stall_w = 6;
  typedef logic [c_stall_w-1:0] stall_bus_t;

  localparam stall_bus_t c_stall_none = {c_stall_w{c_nostop}};
  localparam stall_bus_t c_stall_all  = {c_stall_w{c_stop}};
  localparam stall_bus_t c_stall_mem  = 6'b011111;
  localparam stall_bus_t c_stall_ex   = 6'b001111;
  localparam stall_bus_t c_stall_id   = 6'b000111;
  localparam stall_bus_t c_stall_if   = 6'b000011;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PEND  = 2'd1,
    S_FLUSH = 2'd2
  } ctrl_state_t;

  // The oldest stalled stage wins: it freezes itself and everything younger.
  function automatic stall_bus_t stall_encode(input logic mem_req, input logic ex_req,
                                              input logic id_req, input logic if_req);
    stall_bus_t v;
    if (mem_req)     v = c_stall_mem;
    else if (ex_req) v = c_stall_ex;
    else if (id_req) v = c_stall_id;
    else if (if_req) v = c_stall_if;
    else             v = c_stall_none;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipeline_ctrl_if : stall request / exception / stall-flush bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  exc_code_t   exc_code_i;
  logic [31:0] exc_epc_i;
  logic [31:0] cp0_epc_i;
  stall_bus_t  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        exc_commit;
  logic        stall_tmo;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output exc_code_i, exc_epc_i, cp0_epc_i,
    input  stall, flush, flush_pc, exc_commit, stall_tmo
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  exc_code_i, exc_epc_i, cp0_epc_i,
    output stall, flush, flush_pc, exc_commit, stall_tmo
  );

endinterface
`default_nettype wire

// File: rtl/stall_watchdog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stall_watchdog : saturating stall-cycle counter with sticky timeout flag
// Built only with CTRL_STALL_WATCHDOG_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`ifdef CTRL_STALL_WATCHDOG_EN
module stall_watchdog #(
  parameter logic [15:0] STALL_TMO = 16'd4096
) (
  input  wire  cpu_clk_75M,
  input  wire  cpu_rst_n,
  input  wire  i_stall_any,
  input  wire  i_flush,
  output logic o_stall_tmo
);

  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        r_tmo;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_flush || !i_stall_any) w_cnt_nxt = 16'd0;
    else if (r_cnt != 16'hFFFF)  w_cnt_nxt = r_cnt + 16'd1;
  end

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_cnt <= 16'd0;
      r_tmo <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_cnt_nxt >= STALL_TMO) r_tmo <= 1'b1;
    end
  end

  assign o_stall_tmo = r_tmo;

endmodule
`endif
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipeline_ctrl : MiniMIPS32 stall arbitration, exception/ERET flush and redirect
// Option CTRL_STALL_WATCHDOG_EN adds the stall watchdog.  Rev 1.0
// ----------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
`ifdef CTRL_STALL_WATCHDOG_EN
  ,
  parameter logic [15:0] STALL_TMO  = 16'd4096
`endif
) (
  input  wire            cpu_clk_75M,
  input  wire            cpu_rst_n,
  pipeline_ctrl_if.slave bus
);

  ctrl_state_t r_state;
  ctrl_state_t w_state_nxt;
  logic        r_flush;
  logic        w_flush_nxt;
  logic [31:0] r_flush_pc;
  logic [31:0] w_flush_pc_nxt;
  logic        r_exc_commit;
  logic        w_exc_commit_nxt;
  logic [31:0] r_pend_pc;
  logic [31:0] w_pend_pc_nxt;
  logic        r_pend_commit;
  logic        w_pend_commit_nxt;
  stall_bus_t  w_stall;
  stall_bus_t  w_stall_out;
  logic        w_exc_take;
  logic        w_is_eret;
  logic [31:0] w_exc_target;
  logic        w_stall_tmo;

  assign w_is_eret    = (bus.exc_code_i == c_ec_eret);
  assign w_exc_take   = (bus.exc_code_i != c_ec_none) && !bus.stallreq_mem;
  assign w_exc_target = w_is_eret ? bus.cp0_epc_i : EXC_VECTOR;

  always_comb begin
    w_state_nxt       = r_state;
    w_flush_nxt       = 1'b0;
    w_flush_pc_nxt    = 32'd0;
    w_exc_commit_nxt  = 1'b0;
    w_pend_pc_nxt     = r_pend_pc;
    w_pend_commit_nxt = r_pend_commit;
    w_stall           = c_stall_none;
    case (r_state)
      S_RUN: begin
        w_stall = stall_encode(bus.stallreq_mem, bus.stallreq_ex,
                               bus.stallreq_id, bus.stallreq_if);
        if (w_exc_take) begin
          if (!bus.stallreq_if) begin
            w_state_nxt      = S_FLUSH;
            w_flush_nxt      = 1'b1;
            w_flush_pc_nxt   = w_exc_target;
            w_exc_commit_nxt = !w_is_eret;
          end else begin
            // Fetch still owns the bus; hold the redirect until it lets go.
            w_state_nxt       = S_PEND;
            w_pend_pc_nxt     = w_exc_target;
            w_pend_commit_nxt = !w_is_eret;
          end
        end
      end
      S_PEND: begin
        w_stall = c_stall_all;
        if (!bus.stallreq_if) begin
          w_state_nxt       = S_FLUSH;
          w_flush_nxt       = 1'b1;
          w_flush_pc_nxt    = r_pend_pc;
          w_exc_commit_nxt  = r_pend_commit;
          w_pend_pc_nxt     = 32'd0;
          w_pend_commit_nxt = 1'b0;
        end
      end
      S_FLUSH: w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state       <= S_RUN;
      r_flush       <= 1'b0;
      r_flush_pc    <= 32'd0;
      r_exc_commit  <= 1'b0;
      r_pend_pc     <= 32'd0;
      r_pend_commit <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_flush       <= w_flush_nxt;
      r_flush_pc    <= w_flush_pc_nxt;
      r_exc_commit  <= w_exc_commit_nxt;
      r_pend_pc     <= w_pend_pc_nxt;
      r_pend_commit <= w_pend_commit_nxt;
    end
  end

  // Stall is combinational, so gate it to keep the whole pipe running while in reset.
  assign w_stall_out    = cpu_rst_n ? w_stall : c_stall_none;
  assign bus.stall      = w_stall_out;
  assign bus.flush      = r_flush;
  assign bus.flush_pc   = r_flush_pc;
  assign bus.exc_commit = r_exc_commit;
  assign bus.stall_tmo  = w_stall_tmo;

`ifdef CTRL_STALL_WATCHDOG_EN
  stall_watchdog #(
    .STALL_TMO (STALL_TMO)
  ) u_stall_watchdog (
    .cpu_clk_75M (cpu_clk_75M),
    .cpu_rst_n   (cpu_rst_n),
    .i_stall_any (|w_stall_out),
    .i_flush     (r_flush),
    .o_stall_tmo (w_stall_tmo)
  );
`else
  assign w_stall_tmo = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipeline_ctrl : directed and random stimulus against a cycle reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam logic [31:0] TB_VEC = 32'hBFC0_0380;
  localparam int          TB_TMO = 16;
`ifdef CTRL_STALL_WATCHDOG_EN
  localparam bit          TB_WD  = 1'b1;
`else
  localparam bit          TB_WD  = 1'b0;
`endif

  logic cpu_clk_75M = 1'b0;
  logic cpu_rst_n   = 1'b0;
  int   n_checks    = 0;
  int   n_fail      = 0;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(
    .EXC_VECTOR (TB_VEC)
`ifdef CTRL_STALL_WATCHDOG_EN
    , .STALL_TMO (16'd16)
`endif
  ) dut (
    .cpu_clk_75M (cpu_clk_75M),
    .cpu_rst_n   (cpu_rst_n),
    .bus         (bus)
  );

  always #5 cpu_clk_75M = ~cpu_clk_75M;

  // Reference model: a pending redirect, a flush due this cycle, a stall-cycle count.
  bit          m_pend;
  logic [31:0] m_pend_tgt;
  bit          m_pend_commit;
  bit          m_flush;
  logic [31:0] m_flush_pc;
  bit          m_commit;
  int          m_wd;
  bit          m_tmo;
  logic [5:0]  e_stall;
  logic        e_flush;
  logic [31:0] e_flush_pc;
  logic        e_commit;
  logic        e_tmo;

  function automatic logic [5:0] prio_stall(input logic mem, input logic ex,
                                            input logic id, input logic ifr);
    int n;
    n = mem ? 5 : ex ? 4 : id ? 3 : ifr ? 2 : 0;
    return 6'((1 << n) - 1);
  endfunction

  task automatic model_reset;
    m_pend = 0; m_pend_tgt = '0; m_pend_commit = 0;
    m_flush = 0; m_flush_pc = '0; m_commit = 0;
    m_wd = 0; m_tmo = 0;
  endtask

  task automatic model_expect;
    if (!cpu_rst_n)   e_stall = 6'd0;
    else if (m_flush) e_stall = 6'd0;
    else if (m_pend)  e_stall = 6'h3F;
    else e_stall = prio_stall(bus.stallreq_mem, bus.stallreq_ex, bus.stallreq_id, bus.stallreq_if);
    e_flush    = m_flush;
    e_flush_pc = m_flush ? m_flush_pc : 32'd0;
    e_commit   = m_flush && m_commit;
    e_tmo      = TB_WD && m_tmo;
  endtask

  task automatic model_next;
    logic [31:0] tgt;
    if (e_stall == 0 || m_flush) m_wd = 0;
    else if (m_wd < 65535) m_wd++;
    if (m_wd >= TB_TMO) m_tmo = 1;
    if (m_flush) begin
      m_flush = 0;
    end else if (m_pend) begin
      if (!bus.stallreq_if) begin
        m_flush = 1; m_flush_pc = m_pend_tgt; m_commit = m_pend_commit; m_pend = 0;
      end
    end else if (bus.exc_code_i != c_ec_none && !bus.stallreq_mem) begin
      tgt = (bus.exc_code_i == c_ec_eret) ? bus.cp0_epc_i : TB_VEC;
      if (!bus.stallreq_if) begin
        m_flush = 1; m_flush_pc = tgt; m_commit = (bus.exc_code_i != c_ec_eret);
      end else begin
        m_pend = 1; m_pend_tgt = tgt; m_pend_commit = (bus.exc_code_i != c_ec_eret);
      end
    end
  endtask

  function automatic logic [40:0] obs_vec();
    return {bus.stall, bus.flush, bus.flush_pc, bus.exc_commit, bus.stall_tmo};
  endfunction
  function automatic logic [40:0] exp_vec();
    return {e_stall, e_flush, e_flush_pc, e_commit, e_tmo};
  endfunction
  function automatic string fmt(input logic [40:0] v);
    return $sformatf("stall=%b flush=%b pc=%h commit=%b tmo=%b", v[40:35], v[34], v[33:2], v[1], v[0]);
  endfunction

  task automatic drive(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem,
                       input exc_code_t code, input logic [31:0] epc, input logic [31:0] cp0);
    bus.stallreq_if = r_if; bus.stallreq_id = r_id; bus.stallreq_ex = r_ex; bus.stallreq_mem = r_mem;
    bus.exc_code_i = code; bus.exc_epc_i = epc; bus.cp0_epc_i = cp0;
  endtask

  task automatic half;
    @(negedge cpu_clk_75M);
    model_expect();
  endtask

  task automatic tick;
    model_next();
    @(posedge cpu_clk_75M);
    #1;
  endtask

  task automatic test_reset;
    drive(1, 1, 1, 1, c_ec_syscall, 32'h1, 32'h2);
    cpu_rst_n = 0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge cpu_clk_75M);
      n_checks++;
      if (obs_vec() !== 41'd0) begin
        n_fail++; $display("FAIL reset[%0d]: got %s, want all zero", i, fmt(obs_vec()));
      end
      @(posedge cpu_clk_75M); #1;
    end
    drive(0, 0, 0, 0, c_ec_none, 32'h0, 32'h0);
    cpu_rst_n = 1;
    half();
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_release: got %s, want %s", fmt(obs_vec()), fmt(exp_vec()));
    end
    tick();
  endtask

  task automatic test_ex_stall;
    drive(0, 0, 1, 0, c_ec_none, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      half();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL ex_stall[%0d]: got %s, want %s", i, fmt(obs_vec()), fmt(exp_vec()));
      end
      n_checks++;
      if ({bus.stall, bus.flush} !== {6'b001111, 1'b0}) begin
        n_fail++; $display("FAIL ex_stall_lit[%0d]: got stall=%b flush=%b, want 001111 0", i, bus.stall, bus.flush);
      end
      tick();
    end
    drive(0, 0, 0, 0, c_ec_none, 32'h0, 32'h0);
    half();
    n_checks++;
    if (bus.stall !== 6'd0) begin
      n_fail++; $display("FAIL ex_stall_drop: got stall=%b, want 000000", bus.stall);
    end
    tick();
  endtask

  task automatic test_priority;
    logic [3:0] reqs [6] = '{4'b1010, 4'b0101, 4'b0011, 4'b0001, 4'b1111, 4'b0000};
    logic [5:0] want [6] = '{6'b011111, 6'b001111, 6'b000111, 6'b000011, 6'b011111, 6'b000000};
    for (int i = 0; i < 6; i++) begin
      drive(reqs[i][0], reqs[i][1], reqs[i][2], reqs[i][3], c_ec_none, 32'h0, 32'h0);
      half();
      n_checks++;
      if (bus.stall !== want[i] || obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL priority[%0d]: got %s, want stall=%b (%s)", i, fmt(obs_vec()), want[i], fmt(exp_vec()));
      end
      tick();
    end
  endtask

  task automatic test_redirect(input exc_code_t code, input logic [31:0] cp0,
                               input logic [31:0] want_pc, input logic want_commit);
    drive(0, 0, 0, 0, code, 32'h8000_0010, cp0);
    half();
    n_checks++;
    if (bus.flush !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL redirect_accept: got %s, want %s", fmt(obs_vec()), fmt(exp_vec()));
    end
    tick();
    drive(0, 0, 0, 0, c_ec_none, 32'h0, 32'h0);
    half();
    n_checks++;
    if ({bus.stall, bus.flush, bus.flush_pc, bus.exc_commit} !== {6'd0, 1'b1, want_pc, want_commit}
        || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL redirect_flush: got %s, want pc=%h commit=%b", fmt(obs_vec()), want_pc, want_commit);
    end
    tick();
    half();
    n_checks++;
    if ({bus.stall, bus.flush, bus.flush_pc, bus.exc_commit} !== 40'd0) begin
      n_fail++; $display("FAIL redirect_after: got %s, want zeros", fmt(obs_vec()));
    end
    tick();
  endtask

  task automatic test_syscall;
    test_redirect(c_ec_syscall, 32'h1234_5678, 32'hBFC0_0380, 1'b1);
  endtask

  task automatic test_eret;
    test_redirect(c_ec_eret, 32'h8000_0100, 32'h8000_0100, 1'b0);
  endtask

  task automatic test_pend;
    drive(1, 0, 0, 0, c_ec_eret, 32'h8000_0010, 32'h8000_0200);
    half(); tick();
    for (int k = 0; k < 3; k++) begin
      if (k < 2) drive(1, 0, 0, 0, c_ec_syscall, 32'h0, 32'hDEAD_0000 + 32'(k));
      else       drive(0, 0, 0, 0, c_ec_none, 32'h0, 32'hDEAD_BEEF);
      half();
      n_checks++;
      if (bus.stall !== 6'h3F || bus.flush !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL pend_hold[%0d]: got %s, want stall=111111 flush=0", k, fmt(obs_vec()));
      end
      tick();
    end
    half();
    n_checks++;
    if ({bus.stall, bus.flush, bus.flush_pc, bus.exc_commit} !== {6'd0, 1'b1, 32'h8000_0200, 1'b0}
        || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL pend_flush: got %s, want flush=1 pc=80000200 commit=0", fmt(obs_vec()));
    end
    tick();
  endtask

  task automatic test_mem_blocks;
    logic want_flush [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      if (i < 2) drive(0, 0, 0, 1, c_ec_syscall, 32'h8000_0040, 32'h0);
      else if (i == 2) drive(0, 0, 0, 0, c_ec_syscall, 32'h8000_0040, 32'h0);
      else drive(0, 0, 0, 0, c_ec_none, 32'h0, 32'h0);
      half();
      n_checks++;
      if (bus.flush !== want_flush[i] || (i < 2 && bus.stall !== 6'b011111) || obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL mem_blocks[%0d]: got %s, want %s", i, fmt(obs_vec()), fmt(exp_vec()));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic want_flush [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(0, 0, 0, 0, c_ec_syscall, 32'h8000_0080, 32'h0);
      else       drive(0, 0, 0, 0, c_ec_none, 32'h0, 32'h0);
      half();
      n_checks++;
      if (bus.flush !== want_flush[i] || obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL back_to_back[%0d]: got %s, want %s", i, fmt(obs_vec()), fmt(exp_vec()));
      end
      tick();
    end
  endtask

  task automatic test_reset_pend;
    drive(1, 0, 0, 0, c_ec_syscall, 32'h8000_0010, 32'h0);
    half(); tick();
    half();
    n_checks++;
    if (bus.stall !== 6'h3F) begin
      n_fail++; $display("FAIL reset_pend_enter: got stall=%b, want 111111", bus.stall);
    end
    #2;
    cpu_rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (obs_vec() !== 41'd0) begin
      n_fail++; $display("FAIL reset_pend_async: got %s, want all zero", fmt(obs_vec()));
    end
    @(posedge cpu_clk_75M); #1;
    drive(0, 0, 0, 0, c_ec_none, 32'h0, 32'h0);
    cpu_rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      half();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL reset_pend_after[%0d]: got %s, want %s", i, fmt(obs_vec()), fmt(exp_vec()));
      end
      tick();
    end
  endtask

  task automatic test_random;
    exc_code_t others [4] = '{c_ec_int, c_ec_break, c_ec_ri, c_ec_ov};
    exc_code_t code;
    int sel;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      code = (sel < 7) ? c_ec_none : (sel == 7) ? c_ec_eret : (sel == 8) ? c_ec_syscall
             : others[$urandom_range(0, 3)];
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0, code, $urandom, $urandom);
      half();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d]: got %s, want %s", i, fmt(obs_vec()), fmt(exp_vec()));
      end
      tick();
    end
  endtask

  task automatic test_watchdog;
    @(negedge cpu_clk_75M); #2;
    cpu_rst_n = 0;
    model_reset();
    @(posedge cpu_clk_75M); #1;
    cpu_rst_n = 1;
    for (int i = 0; i < 24; i++) begin
      if (i < 20) drive(0, 0, 1, 0, c_ec_none, 32'h0, 32'h0);
      else        drive(0, 0, 0, 0, c_ec_none, 32'h0, 32'h0);
      half();
      n_checks++;
      if (bus.stall_tmo !== (TB_WD && i >= 16) || obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL watchdog[%0d]: got %s, want tmo=%b (%s)", i, fmt(obs_vec()), TB_WD && i >= 16, fmt(exp_vec()));
      end
      tick();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, c_ec_none, 32'h0, 32'h0);
    model_reset();
    @(posedge cpu_clk_75M); #1;
    test_reset();
    test_ex_stall();
    test_priority();
    test_syscall();
    test_eret();
    test_pend();
    test_mem_blocks();
    test_back_to_back();
    test_reset_pend();
    test_random();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
